ball_motion_ctl: RTL and testbench
==================================

Name: ball_motion_ctl

Overview:
- Generates the ball position (x_pos, y_pos) that feeds collision_detector, and consumes its collision_det output.
- Moves the ball once per video frame and bounces it off walls, the paddle and detected blocks.
- Tracks lost balls and lives; after a loss, parks the ball at the bottom line so the detector's block-reset condition fires.
- Sits between the frame-timing logic and collision_detector/draw_ball in the pclk domain.

Parameters:
STEP, 2, pixels moved per frame on each axis
X_MIN, 10, leftmost ball centre x
X_MAX, 1013, rightmost ball centre x
Y_MIN, 10, topmost ball centre y
PADDLE_Y, 740, ball centre y when resting on / bouncing off paddle
PADDLE_W, 128, paddle width in pixels
Y_LOST, 756, ball centre y at which ball is lost (y_pos+10 == 766)
X_START, 512, ball x after reset
LIVES, 3, lives at reset / restart
LOST_FRAMES, 60, frames ball is held at Y_LOST before re-serve

Ports:
pclk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-pclk pulse per frame; all motion updates occur on it
launch  in  1  level; serve / restart request, sampled only on frame_tick
paddle_x  in  12  paddle left edge
collision_det  in  16  from collision_detector; any nonzero bit = block hit
x_pos  out  12  ball centre x, registered
y_pos  out  12  ball centre y, registered
ball_active  out  1  1 while state is MOVING
ball_lost  out  1  one-pclk pulse on entry to LOST
lives  out  3  remaining lives
game_over  out  1  1 while state is OVER

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, x_pos=X_START, y_pos=PADDLE_Y.
  - dir_x=right, dir_y=up, hit_pend=0, lives=LIVES, lost_cnt=0.
  - ball_active=0, ball_lost=0, game_over=0.
  - Reset mid-move aborts immediately; hit_pend is discarded.
- hit_pend latches:
  - Set on any pclk with |collision_det=1.
  - Cleared on frame_tick in every state.
  - Multiple hits between two ticks act as one bounce.
  - A hit on the same cycle as frame_tick is consumed by that tick.
- Outputs update only on the pclk edge where frame_tick=1, with 1-cycle latency, except ball_lost (pulse) and reset.
- States:
  - IDLE:
    - Each tick: x_pos = paddle_x + PADDLE_W/2, clamped to [X_MIN, X_MAX]; y_pos=PADDLE_Y.
    - If launch=1 on a tick: go to MOVING with dir_x=right, dir_y=up. Position is not advanced on that tick.
  - MOVING, each tick, in order:
    1. If hit_pend: invert dir_y.
    2. nx = x_pos ± STEP; ny = y_pos ± STEP. Compute in 13-bit signed to avoid wrap below 0.
    3. If nx <= X_MIN: x_pos=X_MIN, dir_x=right. Else if nx >= X_MAX: x_pos=X_MAX, dir_x=left. Else x_pos=nx.
    4. If dir_y=up and ny <= Y_MIN: y_pos=Y_MIN, dir_y=down.
    5. Else if dir_y=down, ny >= PADDLE_Y, previous y_pos < PADDLE_Y and paddle_x <= x_pos(new) <= paddle_x+PADDLE_W: y_pos=PADDLE_Y, dir_y=up.
    6. Else if ny >= Y_LOST: y_pos=Y_LOST, go to LOST.
    7. Else y_pos=ny.
  - LOST:
    - On entry: ball_lost pulses 1 cycle; lives decrements (saturating at 0); lost_cnt=0.
    - x_pos/y_pos held (y_pos=Y_LOST).
    - Each tick: lost_cnt+1. When lost_cnt reaches LOST_FRAMES-1: go to OVER if lives==0, else to IDLE.
  - OVER:
    - game_over=1; position held.
    - launch=1 on a tick: lives=LIVES, go to IDLE.
- Corner case: a wall and a hit on the same tick both apply. Hit flips first, then the wall clamp wins for its axis.
- launch outside a tick is ignored. frame_tick held high for multiple cycles steps on every such cycle; the frame-timing logic guarantees single-cycle pulses.

Test Plan:
- Reset, paddle_x=300, one tick -> x_pos=364, y_pos=740, state IDLE, lives=3. launch=1 on the next tick -> ball_active=1, x/y unchanged. Next tick -> x_pos=366, y_pos=738.
- MOVING up from y=12 with STEP=2 -> after one tick y_pos=10, dir down. Next tick -> y_pos=12. At x=1012 moving right -> x_pos=1013, then 1011.
- collision_det=16'h0004 for 1 cycle, then 16'h0008 before the next tick, ball moving up at y=400 -> at tick y_pos=402 (single inversion). Next tick 404.
- Ball moving down at y=739, paddle_x=600, x=650 -> y_pos=740, dir up. Repeat with paddle_x=100 -> continues to 741, and later y_pos=756, ball_lost pulse, lives=2.
- Lose 3 balls -> after 60 ticks in LOST, game_over=1, lives=0. launch on a tick -> lives=3, IDLE. Assert rst_n=0 mid-MOVING -> outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ball_motion_ctl.sv
// Ball position controller: steps the ball once per frame, bounces it off walls, paddle and
// detected blocks, and sequences serve / loss / game-over with a life counter.
module ball_motion_ctl #(
    parameter int STEP        = 2,
    parameter int X_MIN       = 10,
    parameter int X_MAX       = 1013,
    parameter int Y_MIN       = 10,
    parameter int PADDLE_Y    = 740,
    parameter int PADDLE_W    = 128,
    parameter int Y_LOST      = 756,
    parameter int X_START     = 512,
    parameter int LIVES       = 3,
    parameter int LOST_FRAMES = 60
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        launch,
    input  logic [11:0] paddle_x,
    input  logic [15:0] collision_det,
    output logic [11:0] x_pos,
    output logic [11:0] y_pos,
    output logic        ball_active,
    output logic        ball_lost,
    output logic [2:0]  lives,
    output logic        game_over
);

    typedef enum logic [1:0] {IDLE, MOVING, LOST, OVER} state_t;

    localparam int CW = $clog2(LOST_FRAMES);
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam logic signed [12:0] STEP_S     = 13'(STEP);
    localparam logic signed [12:0] X_MIN_S    = 13'(X_MIN);
    localparam logic signed [12:0] X_MAX_S    = 13'(X_MAX);
    localparam logic signed [12:0] Y_MIN_S    = 13'(Y_MIN);
    localparam logic signed [12:0] PADDLE_Y_S = 13'(PADDLE_Y);
    localparam logic signed [12:0] Y_LOST_S   = 13'(Y_LOST);

    state_t          state_q;
    logic [11:0]     x_q, y_q;
    logic            dir_x_q;      // 1 = right
    logic            dir_y_q;
    logic            hit_pend_q;
    logic [2:0]      lives_q;
    logic [CW-1:0]   lost_cnt_q;
    logic            active_q, lost_q, over_q;

    logic               hit_now, dir_y_eff;
    logic signed [12:0] nx, ny;
    logic [11:0]        x_d, y_d, idle_x_d;
    logic               dir_x_d, dir_y_d, to_lost;
    logic [12:0]        idle_sum, paddle_r;

    always_comb begin
        hit_now   = hit_pend_q | (|collision_det);
        dir_y_eff = dir_y_q ^ hit_now;

        // Signed 13-bit step so a move past the left/top edge compares correctly.
        nx = dir_x_q ? $signed({1'b0, x_q}) + STEP_S : $signed({1'b0, x_q}) - STEP_S;
        ny = (dir_y_eff == DIR_DOWN) ? $signed({1'b0, y_q}) + STEP_S
                                     : $signed({1'b0, y_q}) - STEP_S;

        x_d     = nx[11:0];
        dir_x_d = dir_x_q;
        if (nx <= X_MIN_S) begin
            x_d     = 12'(X_MIN);
            dir_x_d = 1'b1;
        end else if (nx >= X_MAX_S) begin
            x_d     = 12'(X_MAX);
            dir_x_d = 1'b0;
        end

        paddle_r = {1'b0, paddle_x} + 13'(PADDLE_W);
        y_d      = ny[11:0];
        dir_y_d  = dir_y_eff;
        to_lost  = 1'b0;
        if (dir_y_eff == DIR_UP && ny <= Y_MIN_S) begin
            y_d     = 12'(Y_MIN);
            dir_y_d = DIR_DOWN;
        end else if (dir_y_eff == DIR_DOWN && ny >= PADDLE_Y_S && y_q < 12'(PADDLE_Y)
                     && paddle_x <= x_d && {1'b0, x_d} <= paddle_r) begin
            y_d     = 12'(PADDLE_Y);
            dir_y_d = DIR_UP;
        end else if (ny >= Y_LOST_S) begin
            y_d     = 12'(Y_LOST);
            to_lost = 1'b1;
        end

        idle_sum = {1'b0, paddle_x} + 13'(PADDLE_W / 2);
        if (idle_sum >= 13'(X_MAX))      idle_x_d = 12'(X_MAX);
        else if (idle_sum <= 13'(X_MIN)) idle_x_d = 12'(X_MIN);
        else                             idle_x_d = idle_sum[11:0];
    end

    // NOTE: all state below is updated with non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational block above.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            x_q        <= 12'(X_START);
            y_q        <= 12'(PADDLE_Y);
            dir_x_q    <= 1'b1;
            dir_y_q    <= DIR_UP;
            hit_pend_q <= 1'b0;
            lives_q    <= 3'(LIVES);
            lost_cnt_q <= '0;
            active_q   <= 1'b0;
            lost_q     <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            lost_q <= 1'b0;
            if (frame_tick) begin
                hit_pend_q <= 1'b0;
                case (state_q)
                    IDLE: begin
                        x_q <= idle_x_d;
                        y_q <= 12'(PADDLE_Y);
                        if (launch) begin
                            state_q  <= MOVING;
                            dir_x_q  <= 1'b1;
                            dir_y_q  <= DIR_UP;
                            active_q <= 1'b1;
                        end
                    end
                    MOVING: begin
                        x_q     <= x_d;
                        y_q     <= y_d;
                        dir_x_q <= dir_x_d;
                        dir_y_q <= dir_y_d;
                        if (to_lost) begin
                            state_q    <= LOST;
                            active_q   <= 1'b0;
                            lost_q     <= 1'b1;
                            lost_cnt_q <= '0;
                            if (lives_q != 3'd0) lives_q <= lives_q - 3'd1;
                        end
                    end
                    LOST: begin
                        if (lost_cnt_q == CW'(LOST_FRAMES - 1)) begin
                            if (lives_q == 3'd0) begin
                                state_q <= OVER;
                                over_q  <= 1'b1;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            lost_cnt_q <= lost_cnt_q + 1'b1;
                        end
                    end
                    OVER: begin
                        if (launch) begin
                            state_q <= IDLE;
                            lives_q <= 3'(LIVES);
                            over_q  <= 1'b0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (|collision_det) begin
                hit_pend_q <= 1'b1;
            end
        end
    end

    assign x_pos       = x_q;
    assign y_pos       = y_q;
    assign ball_active = active_q;
    assign ball_lost   = lost_q;
    assign lives       = lives_q;
    assign game_over   = over_q;

endmodule

// File: tb/tb_ball_motion_ctl.sv
// Self-checking bench for ball_motion_ctl: per-cycle comparison against a frame-level
// behavioural model, plus directed literal checks of bounces, losses and game over.
module tb_ball_motion_ctl;

    logic        pclk = 1'b0;
    logic        rst_n, frame_tick, launch;
    logic [11:0] paddle_x;
    logic [15:0] collision_det;
    logic [11:0] x_pos, y_pos;
    logic        ball_active, ball_lost, game_over;
    logic [2:0]  lives;

    ball_motion_ctl dut (
        .pclk(pclk), .rst_n(rst_n), .frame_tick(frame_tick), .launch(launch),
        .paddle_x(paddle_x), .collision_det(collision_det),
        .x_pos(x_pos), .y_pos(y_pos), .ball_active(ball_active), .ball_lost(ball_lost),
        .lives(lives), .game_over(game_over)
    );

    always #5 pclk = ~pclk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-level model: velocity signs and plain integer arithmetic.
    localparam int S_IDLE = 0, S_MOVING = 1, S_LOST = 2, S_OVER = 3;
    int m_state, mx, my, vx, vy, m_lives, m_frames, nx, ny;
    bit m_hit, m_lost, hit_now;

    always @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = S_IDLE; mx = 512; my = 740; vx = 1; vy = -1;
            m_hit = 0; m_lives = 3; m_frames = 0; m_lost = 0;
        end else begin
            hit_now = m_hit || (collision_det != 0);
            m_lost  = 0;
            if (frame_tick) begin
                m_hit = 0;
                case (m_state)
                    S_IDLE: begin
                        mx = int'(paddle_x) + 64;
                        if (mx > 1013) mx = 1013;
                        if (mx < 10) mx = 10;
                        my = 740;
                        if (launch) begin m_state = S_MOVING; vx = 1; vy = -1; end
                    end
                    S_MOVING: begin
                        if (hit_now) vy = -vy;
                        nx = mx + 2 * vx;
                        ny = my + 2 * vy;
                        if (nx <= 10) begin mx = 10; vx = 1; end
                        else if (nx >= 1013) begin mx = 1013; vx = -1; end
                        else mx = nx;
                        if (vy < 0 && ny <= 10) begin my = 10; vy = 1; end
                        else if (vy > 0 && ny >= 740 && my < 740 &&
                                 int'(paddle_x) <= mx && mx <= int'(paddle_x) + 128) begin
                            my = 740; vy = -1;
                        end else if (ny >= 756) begin
                            my = 756; m_state = S_LOST; m_lost = 1; m_frames = 0;
                            if (m_lives > 0) m_lives--;
                        end else my = ny;
                    end
                    S_LOST: begin
                        m_frames++;
                        if (m_frames == 60) m_state = (m_lives == 0) ? S_OVER : S_IDLE;
                    end
                    default: if (launch) begin m_lives = 3; m_state = S_IDLE; end
                endcase
            end else begin
                m_hit = hit_now;
            end
        end
    end

    always @(negedge pclk) begin
        if (rst_n === 1'b1) begin
            check("cyc_x", x_pos, mx);
            check("cyc_y", y_pos, my);
            check("cyc_flags", {ball_active, ball_lost, game_over},
                  {m_state == S_MOVING, m_lost, m_state == S_OVER});
            check("cyc_lives", lives, m_lives);
        end
    end

    logic lost_seen;

    // Called on a negedge; one tick cycle, then one quiet cycle.
    task automatic do_tick(input logic l, input logic [15:0] c = 16'h0);
        frame_tick = 1'b1; launch = l; collision_det = c;
        @(negedge pclk);
        frame_tick = 1'b0; launch = 1'b0; collision_det = 16'h0;
        lost_seen = ball_lost;
        @(negedge pclk);
    endtask

    task automatic pulse_hit(input logic [15:0] c);
        collision_det = c;
        @(negedge pclk);
        collision_det = 16'h0;
        @(negedge pclk);
    endtask

    task automatic lose_ball(input logic serve);
        if (serve) do_tick(1'b1);
        for (int i = 0; i < 2000 && m_state == S_MOVING; i++) begin
            if (vy > 0 && my == 738) paddle_x = (mx < 512) ? 12'd1000 : 12'd0;
            do_tick(1'b0);
        end
        check("lose_reached_lost", m_state, S_LOST);
        check("lose_pulse", lost_seen, 1'b1);
        check("lose_y", y_pos, 756);
    endtask

    initial begin
        rst_n = 1'b0; frame_tick = 1'b0; launch = 1'b0;
        paddle_x = 12'd300; collision_det = 16'h0;
        repeat (3) @(negedge pclk);
        rst_n = 1'b1;
        @(negedge pclk);
        check("rst_x", x_pos, 512);
        check("rst_y", y_pos, 740);
        check("rst_lives", lives, 3);
        check("rst_flags", {ball_active, ball_lost, game_over}, 3'b000);

        do_tick(1'b0);
        check("idle_x", x_pos, 364);
        check("idle_y", y_pos, 740);
        check("idle_active", ball_active, 1'b0);
        do_tick(1'b1);
        check("launch_active", ball_active, 1'b1);
        check("launch_x", x_pos, 364);
        check("launch_y", y_pos, 740);
        do_tick(1'b0);
        check("first_x", x_pos, 366);
        check("first_y", y_pos, 738);

        for (int i = 0; i < 1000 && !(mx == 1012 && vx > 0); i++) do_tick(1'b0);
        do_tick(1'b0);
        check("wall_right", x_pos, 1013);
        do_tick(1'b0);
        check("wall_right_back", x_pos, 1011);

        for (int i = 0; i < 1000 && !(my == 12 && vy < 0); i++) do_tick(1'b0);
        do_tick(1'b0);
        check("wall_top", y_pos, 10);
        do_tick(1'b0);
        check("wall_top_back", y_pos, 12);

        for (int i = 0; i < 1000 && !(my == 400 && vy > 0); i++) do_tick(1'b0);
        pulse_hit(16'h0004);
        pulse_hit(16'h0008);
        do_tick(1'b0);
        check("hit_single_flip", y_pos, 398);
        do_tick(1'b0);
        check("hit_after", y_pos, 396);
        do_tick(1'b0, 16'h0001);
        check("hit_on_tick", y_pos, 398);
        do_tick(1'b0);
        check("hit_on_tick_after", y_pos, 400);

        for (int i = 0; i < 1000 && !(my == 738 && vy > 0); i++) do_tick(1'b0);
        paddle_x = (mx >= 60) ? 12'(mx - 60) : 12'd0;
        do_tick(1'b0);
        check("paddle_bounce_y", y_pos, 740);
        check("paddle_bounce_active", ball_active, 1'b1);
        do_tick(1'b0);
        check("paddle_bounce_up", y_pos, 738);

        for (int i = 0; i < 1000 && !(my == 738 && vy > 0); i++) do_tick(1'b0);
        paddle_x = (mx < 512) ? 12'd1000 : 12'd0;
        do_tick(1'b0);
        check("paddle_miss_y", y_pos, 740);
        do_tick(1'b0);
        check("paddle_miss_y2", y_pos, 742);
        lose_ball(1'b0);
        check("lives_after_1", lives, 2);

        repeat (59) do_tick(1'b0);
        check("lost_hold_active", ball_active, 1'b0);
        check("lost_hold_y", y_pos, 756);
        paddle_x = 12'd200;
        do_tick(1'b0);
        check("lost_60th_y", y_pos, 756);
        do_tick(1'b0);
        check("reidle_x", x_pos, 264);
        check("reidle_y", y_pos, 740);
        paddle_x = 12'd4000;
        do_tick(1'b0);
        check("idle_clamp_x", x_pos, 1013);

        lose_ball(1'b1);
        check("lives_after_2", lives, 1);
        repeat (60) do_tick(1'b0);
        lose_ball(1'b1);
        check("lives_after_3", lives, 0);
        repeat (60) do_tick(1'b0);
        check("over_flag", game_over, 1'b1);
        check("over_lives", lives, 0);

        launch = 1'b1;
        repeat (3) @(negedge pclk);
        launch = 1'b0;
        @(negedge pclk);
        check("launch_no_tick", game_over, 1'b1);
        do_tick(1'b1);
        check("restart_over", game_over, 1'b0);
        check("restart_lives", lives, 3);
        check("restart_active", ball_active, 1'b0);

        paddle_x = 12'd300;
        do_tick(1'b1);
        repeat (5) do_tick(1'b0);
        check("pre_reset_active", ball_active, 1'b1);
        collision_det = 16'h0001;
        @(posedge pclk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_x", x_pos, 512);
        check("async_rst_y", y_pos, 740);
        check("async_rst_lives", lives, 3);
        check("async_rst_flags", {ball_active, ball_lost, game_over}, 3'b000);
        collision_det = 16'h0;
        @(negedge pclk);
        rst_n = 1'b1;
        @(negedge pclk);
        do_tick(1'b0);
        check("post_rst_idle_x", x_pos, 364);
        do_tick(1'b1);
        do_tick(1'b0);
        check("post_rst_move_y", y_pos, 738);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
